pu_or1k_branch_predictor_gshare: RTL
====================================

# pu_or1k_branch_predictor_gshare

Parametrised successor to the single 2-bit saturating-counter predictor. It holds a table of N-bit saturating counters, indexed by decode-stage PC bits XOR a global branch history register (GHR). It predicts l.bf/l.bnf outcome in decode and trains the counter that made the prediction when the branch resolves. It sits in the decode/execute path of the OR1K pipeline, and its predicted flag output drives the fetch redirect logic.

## Interface
Parameters:
- COUNTER_WIDTH, 2: bits per saturating counter; legal range ≥2.
- INDEX_WIDTH, 6: log2 of table depth (64 entries).
- HISTORY_WIDTH, 6: GHR bits; legal range ≤ INDEX_WIDTH.
- OPTION_OPERAND_WIDTH, 32: PC width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- pc_i  in  OPTION_OPERAND_WIDTH  PC of the instruction in decode.
- op_bf_i / op_bnf_i  in  1 each  current decode instruction is l.bf / l.bnf.
- padv_decode_i  in  1  decode stage advances this cycle.
- predicted_flag_o  out  1  predicted flag for the current branch.
- execute_op_bf_i / execute_op_bnf_i  in  1 each  instruction in execute is l.bf / l.bnf.
- flag_i  in  1  resolved SR[F] for the execute branch.
- prev_op_brcond_i  in  1  execute holds a conditional branch being resolved.
- init_done_o  out  1  table initialisation complete.

## Operation
- Counter reset value is WEAK_TAKEN = 2^(COUNTER_WIDTH-1). Prediction taken = counter MSB.
- predicted_flag_o = (msb && op_bf_i) || (!msb && op_bnf_i). The output is 0 when neither op_bf_i nor op_bnf_i is asserted.
- Lookup index = pc_i[INDEX_WIDTH+1:2] XOR zero-extended GHR. pc_i[1:0] is ignored.
- Index capture: on padv_decode_i && (op_bf_i || op_bnf_i), pred_idx_q is set to the lookup index. pred_idx_q holds otherwise.
- brn_taken = (execute_op_bf_i && flag_i) || (execute_op_bnf_i && !flag_i).
- Update condition: prev_op_brcond_i && padv_decode_i && init_done_o.
  - On update, table[pred_idx_q] increments if brn_taken and decrements otherwise.
  - The counter saturates at 0 and at 2^COUNTER_WIDTH-1 with no wrap.
- GHR: on each update, GHR is set to {GHR[HISTORY_WIDTH-2:0], brn_taken}. The GHR is not speculatively updated.
- Init FSM (the table has no per-entry reset so it maps to distributed RAM):
  - INIT: writes WEAK_TAKEN to entry init_idx and increments init_idx each cycle. After entry 2^INDEX_WIDTH-1 it moves to RUN. Training updates are dropped during INIT.
  - During INIT, predicted_flag_o = op_bf_i, which is the static weakly-taken behaviour.
  - RUN: normal operation. The FSM stays in RUN until reset.
- Simultaneous lookup and update to the same entry: the lookup returns the pre-update value (read-before-write).

## Timing
- Reset (asynchronous assert on rst=0):
  - State=INIT, init_idx=0, GHR=0, pred_idx_q=0.
  - init_done_o=0.
  - predicted_flag_o follows op_bf_i combinationally.
- Reset asserted mid-operation aborts any update and restarts INIT. Deassertion is synchronised externally.
- Initialisation takes 2^INDEX_WIDTH cycles after reset release. init_done_o rises on the cycle after the last init write.
- Prediction is combinational: 0-cycle latency from pc_i, op_bf_i/op_bnf_i, GHR and table contents.
- Counter, GHR and pred_idx_q update on the rising clk edge in the cycle the update condition holds. The new value is visible to lookups in the next cycle.
- Stall (padv_decode_i=0): no update and no index capture, even if prev_op_brcond_i is asserted.

## Configuration
- PU_OR1K_BP_GSHARE_HISTORY_EN defined: GHR is present and the index uses XOR hashing as above.
- PU_OR1K_BP_GSHARE_HISTORY_EN undefined:
  - No GHR flops exist and the index = pc_i[INDEX_WIDTH+1:2] (bimodal predictor).
  - HISTORY_WIDTH is ignored.
  - All other behaviour is identical.

## Structure
- Shared package pu_or1k_pkg holds:
  - the FSM state enum (BP_INIT, BP_RUN);
  - the default COUNTER_WIDTH, INDEX_WIDTH and HISTORY_WIDTH constants;
  - a saturating increment/decrement function parametrised on width.
- One sub-module, pu_or1k_branch_predictor_counter_table, holds the counter array. It has:
  - one asynchronous read port;
  - one synchronous write port shared by the init sweep and training, with the init sweep having priority.
- The top level holds the FSM, GHR, pred_idx_q and the hash logic.

## Test plan
- Reset then idle with defaults:
  - init_done_o=0 for 64 cycles, then 1.
  - During init, op_bf_i=1 gives predicted_flag_o=1 and op_bnf_i=1 gives 0.
- Train pc=0x100 with l.bf not taken 2 times, GHR disabled: the counter goes 2→1→0, and the next l.bf at 0x100 predicts 0. A third not-taken keeps the counter at 0.
- Train taken 3 times from weak-taken: the counter saturates at 3. One not-taken gives 2, and the prediction remains taken.
- Same PC under GHR enabled with GHR=6'b000001: a distinct entry is used, pc index 0 XOR 1 = entry 1, and entry 0 is unchanged.
- padv_decode_i=0 with prev_op_brcond_i=1: the counter and GHR are unchanged. Lookup and update on the same index in one cycle returns the old value.
- Assert rst mid-training: GHR=0, init_done_o=0, and after 64 cycles all entries read WEAK_TAKEN.

Source files
------------

// File: rtl/pu_or1k_pkg.sv
// Shared types and helpers for the OR1K branch predictor: FSM states, default sizes, saturating step.
// No logic of its own; zero latency; no flow control.
// Carries no backpressure; the consumers decide when to use these helpers.
package pu_or1k_pkg;

    typedef enum logic {
        BP_INIT = 1'b0,
        BP_RUN  = 1'b1
    } bp_state_t;

    localparam int BP_COUNTER_WIDTH = 2;
    localparam int BP_INDEX_WIDTH   = 6;
    localparam int BP_HISTORY_WIDTH = 6;

    // Width-generic saturating +/-1; callers truncate the result to their counter width.
    function automatic logic [31:0] sat_step(input logic [31:0] val, input logic up,
                                             input int unsigned width);
        logic [31:0] max_v;
        max_v = (32'd1 << width) - 32'd1;
        if (up) begin
            return (val == max_v) ? val : val + 32'd1;
        end
        return (val == 32'd0) ? val : val - 32'd1;
    endfunction

endpackage

// File: rtl/pu_or1k_branch_predictor_counter_table.sv
// Saturating-counter array: one async read port, one sync write port (init sweep beats training).
// Read is combinational (0 cycles); writes land on the rising clk edge, read-before-write.
// No backpressure: every write request presented is committed the same cycle.
module pu_or1k_branch_predictor_counter_table
    import pu_or1k_pkg::*;
#(
    parameter int COUNTER_WIDTH = BP_COUNTER_WIDTH,
    parameter int INDEX_WIDTH   = BP_INDEX_WIDTH
) (
    input  logic                     clk,
    input  logic [INDEX_WIDTH-1:0]   rd_idx,
    output logic [COUNTER_WIDTH-1:0] rd_dat,
    input  logic                     init_en,
    input  logic [INDEX_WIDTH-1:0]   init_idx,
    input  logic                     upd_en,
    input  logic [INDEX_WIDTH-1:0]   upd_idx,
    input  logic                     upd_up
);

    localparam logic [COUNTER_WIDTH-1:0] WEAK_TAKEN = {1'b1, {(COUNTER_WIDTH-1){1'b0}}};

    // Deliberately no reset so the array can map to distributed RAM.
    logic [COUNTER_WIDTH-1:0] mem [2**INDEX_WIDTH];

    logic                     wr_en;
    logic [INDEX_WIDTH-1:0]   wr_idx;
    logic [COUNTER_WIDTH-1:0] wr_dat;

    assign rd_dat = mem[rd_idx];

    always_comb begin
        wr_en  = init_en | upd_en;
        wr_idx = init_en ? init_idx : upd_idx;
        wr_dat = init_en ? WEAK_TAKEN
                         : COUNTER_WIDTH'(sat_step(32'(mem[upd_idx]), upd_up, COUNTER_WIDTH));
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_dat;
        end
    end

endmodule

// File: rtl/pu_or1k_branch_predictor_gshare.sv
// gshare/bimodal l.bf/l.bnf predictor; PU_OR1K_BP_GSHARE_HISTORY_EN adds the GHR XOR hash.
// Prediction is combinational (0 cycles); training, GHR and index capture commit on the clk edge.
// Stalls (padv_decode_i=0) freeze capture and training; training is dropped until init completes.
module pu_or1k_branch_predictor_gshare
    import pu_or1k_pkg::*;
#(
    parameter int COUNTER_WIDTH        = BP_COUNTER_WIDTH,
    parameter int INDEX_WIDTH          = BP_INDEX_WIDTH,
    parameter int HISTORY_WIDTH        = BP_HISTORY_WIDTH,
    parameter int OPTION_OPERAND_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [OPTION_OPERAND_WIDTH-1:0] pc_i,
    input  logic                            op_bf_i,
    input  logic                            op_bnf_i,
    input  logic                            padv_decode_i,
    output logic                            predicted_flag_o,
    input  logic                            execute_op_bf_i,
    input  logic                            execute_op_bnf_i,
    input  logic                            flag_i,
    input  logic                            prev_op_brcond_i,
    output logic                            init_done_o
);

    bp_state_t                state_q, state_d;
    logic [INDEX_WIDTH-1:0]   init_idx_q;
    logic [INDEX_WIDTH-1:0]   pred_idx_q;
    logic [INDEX_WIDTH-1:0]   pc_idx;
    logic [INDEX_WIDTH-1:0]   lookup_idx;
    logic [COUNTER_WIDTH-1:0] rd_cnt;
    logic                     init_active;
    logic                     brn_taken;
    logic                     do_update;
    logic                     unused_pc;

    assign pc_idx    = pc_i[INDEX_WIDTH+1:2];
    assign unused_pc = ^{pc_i[OPTION_OPERAND_WIDTH-1:INDEX_WIDTH+2], pc_i[1:0]};

`ifdef PU_OR1K_BP_GSHARE_HISTORY_EN
    logic [HISTORY_WIDTH-1:0] ghr_q;
    logic [INDEX_WIDTH-1:0]   ghr_ext;

    always_comb begin
        ghr_ext                    = '0;
        ghr_ext[HISTORY_WIDTH-1:0] = ghr_q;
    end

    assign lookup_idx = pc_idx ^ ghr_ext;

    // History only advances on resolved branches, never speculatively.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr_q <= '0;
        end else if (do_update) begin
            ghr_q <= {ghr_q[HISTORY_WIDTH-2:0], brn_taken};
        end
    end
`else
    assign lookup_idx = pc_idx;
`endif

    assign init_active = (state_q == BP_INIT);
    assign init_done_o = (state_q == BP_RUN);
    assign brn_taken   = (execute_op_bf_i & flag_i) | (execute_op_bnf_i & ~flag_i);
    assign do_update   = prev_op_brcond_i & padv_decode_i & init_done_o;

    // While the table is being swept, fall back to static weakly-taken.
    assign predicted_flag_o = init_active ? op_bf_i
                            : (rd_cnt[COUNTER_WIDTH-1] & op_bf_i) |
                              (~rd_cnt[COUNTER_WIDTH-1] & op_bnf_i);

    always_comb begin
        state_d = state_q;
        if (state_q == BP_INIT && init_idx_q == '1) begin
            state_d = BP_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= BP_INIT;
            init_idx_q <= '0;
            pred_idx_q <= '0;
        end else begin
            state_q <= state_d;
            if (init_active) begin
                init_idx_q <= init_idx_q + 1'b1;
            end
            if (padv_decode_i && (op_bf_i || op_bnf_i)) begin
                pred_idx_q <= lookup_idx;
            end
        end
    end

    pu_or1k_branch_predictor_counter_table #(
        .COUNTER_WIDTH (COUNTER_WIDTH),
        .INDEX_WIDTH   (INDEX_WIDTH)
    ) u_table (
        .clk      (clk),
        .rd_idx   (lookup_idx),
        .rd_dat   (rd_cnt),
        .init_en  (init_active),
        .init_idx (init_idx_q),
        .upd_en   (do_update),
        .upd_idx  (pred_idx_q),
        .upd_up   (brn_taken)
    );

endmodule
